// File: rtl/serial_ripple_carry_4_bit_add_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the bit-serial ripple-carry adder:
//   - state_e      : controller states (IDLE, RUN, DONE)
//   - cnt_w()      : bit-counter width for a given operand width ($clog2)
//   - width_ok()   : legality check for the WIDTH parameter (2..16)
// No ports; imported by the adder top level.
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must index bits 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_ripple_carry_4_bit_add_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder_1bit
// Purely combinational one-bit full-adder slice.
// Ports:
//   a, b  : input operand bits
//   ci    : carry in
//   s     : sum bit      = a ^ b ^ ci
//   co    : carry out    = majority(a, b, ci)
// -----------------------------------------------------------------------------
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_ripple_carry_4_bit_add.sv
// -----------------------------------------------------------------------------
// serial_ripple_carry_4_bit_add
// Bit-serial adder: {Cout, Sum} = A + B + Cin, one bit per clock, LSB first,
// through a single full-adder slice with a registered carry.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-high
//   start : request; A, B, Cin sampled on the same edge (ignored while busy)
//   A, B  : WIDTH-bit addends
//   Cin   : carry in
//   Sum   : registered WIDTH-bit sum (final when done=1, held in IDLE)
//   Cout  : registered carry out
//   busy  : high while bits are being processed
//   done  : one-cycle pulse marking the result as valid
// -----------------------------------------------------------------------------
module serial_ripple_carry_4_bit_add
  import adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_w(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_ripple_carry_4_bit_add: WIDTH must be in 2..16");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic               carry_q, carry_d;
  logic               cout_q,  cout_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               fa_s;
  logic               fa_co;

  full_adder_1bit u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state, datapath shifting and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start too, giving back-to-back operation.
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          sum_d   = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flags are registered from the next state so they align with state_q.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_ripple_carry_4_bit_add.sv
// -----------------------------------------------------------------------------
// tb_serial_ripple_carry_4_bit_add
// Self-checking bench: a cycle-level behavioural model (operation start times
// plus integer sums) predicts busy/done/Sum/Cout every cycle; directed
// operations additionally pin results to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_serial_ripple_carry_4_bit_add;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  serial_ripple_carry_4_bit_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Sum   (Sum),
    .Cout  (Cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // cyc = number of the last rising edge; an operation accepted at edge acc
  // is busy in cycles acc..acc+W-1 and done in cycle acc+W.
  int       cyc = 0;
  int       acc = 0;
  bit       inflight = 1'b0;
  bit       armed = 1'b0;
  logic [W:0] pend = '0;
  logic [W:0] held = '0;

  always @(posedge clk) begin
    bit busy_before;
    cyc <= cyc + 1;
    busy_before = inflight && (cyc < acc + W);
    if (rst) begin
      inflight <= 1'b0;
      held     <= '0;
      armed    <= 1'b1;
    end else begin
      if (inflight && cyc == acc + W) held <= pend;
      if (start && !busy_before) begin
        acc      <= cyc + 1;
        pend     <= (W+1)'(A) + (W+1)'(B) + (W+1)'(Cin);
        inflight <= 1'b1;
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    bit exp_busy, exp_done;
    logic [W:0] exp_res;
    if (armed) begin
      exp_busy = inflight && (cyc < acc + W);
      exp_done = inflight && (cyc == acc + W);
      tests++;
      if (busy !== exp_busy || done !== exp_done) begin
        fails++;
        $display("FAIL flags cyc=%0d busy=%b done=%b expected busy=%b done=%b",
                 cyc, busy, done, exp_busy, exp_done);
      end
      if (!exp_busy) begin
        exp_res = exp_done ? pend : held;
        tests++;
        if ({Cout, Sum} !== exp_res) begin
          fails++;
          $display("FAIL result cyc=%0d got Cout=%b Sum=%b expected Cout=%b Sum=%b",
                   cyc, Cout, Sum, exp_res[W], exp_res[W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input string name, input logic [W-1:0] es, input logic ec);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * W && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s no done pulse within %0d cycles", name, 3 * W);
    end else if (Sum !== es || Cout !== ec) begin
      fails++;
      $display("FAIL %s got Cout=%b Sum=%b expected Cout=%b Sum=%b", name, Cout, Sum, ec, es);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] es, input logic ec);
    @(posedge clk); #1;
    start = 1'b1; A = a; B = b; Cin = cin;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    wait_done(name, es, ec);
  endtask

  initial begin
    logic [W-1:0] xs [4];
    logic [W-1:0] ys [4];
    logic [W-1:0] diff;
    logic         bout;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (Sum !== 4'b0000 || Cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state Sum=%b Cout=%b busy=%b done=%b expected all zero",
               Sum, Cout, busy, done);
    end

    run_op("add_1101_0101_c0", 4'b1101, 4'b0101, 1'b0, 4'b0010, 1'b1);
    run_op("add_1101_0101_c1", 4'b1101, 4'b0101, 1'b1, 4'b0011, 1'b1);
    run_op("inverse_1000_0101", 4'b1000, 4'b0101, 1'b0, 4'b1101, 1'b0);
    run_op("ones_plus_zero_c1", 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);
    run_op("ones_plus_ones_c1", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
    run_op("zero_plus_zero", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Rebuild minuend X from subtractor outputs: Diff + Y + Bin == X, Cout == Bout.
    xs = '{4'b0101, 4'b0101, 4'b1101, 4'b1101};
    ys = '{4'b1101, 4'b0101, 4'b1101, 4'b0101};
    for (int p = 0; p < 4; p++) begin
      for (int bin = 0; bin < 2; bin++) begin
        diff = xs[p] - ys[p] - W'(bin);
        bout = (int'(xs[p]) < int'(ys[p]) + bin);
        run_op("inverse_pair", diff, ys[p], 1'(bin), xs[p], bout);
      end
    end

    // start pulses in RUN cycles 2-3 with other operands must be ignored.
    @(posedge clk); #1;
    start = 1'b1; A = 4'b0011; B = 4'b0100; Cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; A = 4'b1111; B = 4'b1111; Cin = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore_start", 4'b0111, 1'b0);

    // start held high: back-to-back operations with changing operands.
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (W + 2) @(posedge clk);

    // Reset during the second RUN cycle aborts the operation.
    #1;
    start = 1'b1; A = 4'b1010; B = 4'b0110; Cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (Sum !== 4'b0000 || Cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset Sum=%b Cout=%b busy=%b done=%b expected all zero",
               Sum, Cout, busy, done);
    end
    repeat (W + 2) @(posedge clk);
    run_op("after_reset", 4'b0111, 4'b1001, 1'b1, 4'b0001, 1'b1);

    // Random operations with gaps and random start pokes while busy.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    end
    start = 1'b0;
    repeat (2 * W) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_ripple_carry_4_bit_add.md
Name: serial_ripple_carry_4_bit_add

Overview:
- Bit-serial adder that is the inverse operation of the ripple-borrow subtractor: computes {Cout, Sum} = A + B + Cin.
- Processes one bit per clock, LSB first, through a single registered full-adder slice.
- Start/busy/done handshake; the result is held until the next accepted start.
- Used to rebuild the minuend from the subtractor outputs (X = Diff + Y, with the borrow chain checked) and as the sequential adder for the datapath.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range 2..16.

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous reset, active-high
start  input   1      request; operands sampled on the same edge
A      input   WIDTH  addend
B      input   WIDTH  addend
Cin    input   1      carry in
Sum    output  WIDTH  registered sum
Cout   output  1      registered carry out
busy   output  1      high while bits are being processed
done   output  1      one-cycle pulse; Sum/Cout valid from this cycle on

Behaviour:
- Reset: synchronous, active-high. Values after reset:
  - state=IDLE, bit counter=0, internal carry=0
  - Sum=0, Cout=0, busy=0, done=0
- Reset mid-operation aborts the addition with no done pulse; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 on edge k captures A, B and Cin into shift/carry registers, clears the Sum shift register, counter=0, goes to RUN. start=0 stays in IDLE.
  - RUN: each edge computes s=a[0]^b[0]^c and c'=maj(a[0],b[0],c). It shifts s into the Sum MSB (Sum shifts right), shifts A and B right, updates c and increments the counter. When the counter reaches WIDTH-1 on an edge, that edge processes the final bit, loads Cout=c' and goes to DONE.
  - DONE: done=1 for exactly one cycle. If start=1 on this edge, behave as IDLE+start (back-to-back accepted); otherwise go to IDLE.
- Latency: with start sampled at edge k, Sum/Cout are final and done=1 after edge k+WIDTH, i.e. in cycle k+WIDTH. Throughput is one result per WIDTH+1 cycles when start is held high.
- busy=1 exactly when state==RUN; busy and done are never high together.
- Sum/Cout may change during RUN (Sum shifts); they are only meaningful when done=1 or in IDLE afterwards. In IDLE they hold the last result.
- start while busy=1 is ignored; operand changes during RUN have no effect.
- Arithmetic is modulo 2^WIDTH plus carry, so Cout=1 exactly when A+B+Cin ≥ 2^WIDTH.
- Edge case: Cin=1 with A=B=all-ones gives Sum=all-ones, Cout=1.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package, adder_pkg:
  - state enum {IDLE, RUN, DONE}
  - counter width constant CNT_W = $clog2(WIDTH)
  - the WIDTH legality range check
- One natural sub-module: full_adder_1bit (combinational s/c' slice), instantiated once.
- The top level owns the FSM, the shift registers and the carry flop.

Test Plan:
- A=1101, B=0101, Cin=0, start pulse → busy for 4 cycles, then done=1 with Sum=0010, Cout=1. Cin=1 → Sum=0011, Cout=1.
- Inverse check: A=1000 (Diff of 1101-0101), B=0101, Cin=0 → Sum=1101, Cout=0. Repeat for pairs 0101/1101, 0101/0101 and 1101/1101 with Bin in {0,1}: reconstructed X matches the subtractor input.
- A=1111, B=0000, Cin=1 → Sum=0000, Cout=1. A=1111, B=1111, Cin=1 → Sum=1111, Cout=1. A=0000, B=0000, Cin=0 → Sum=0000, Cout=0.
- start asserted in cycles 2-3 of RUN with different operands → ignored; result matches the first operands; done appears in cycle k+4 only.
- start held high continuously → results every 5 cycles, done one cycle each, busy never overlapping done.
- rst=1 during the 2nd RUN cycle → next edge: busy=0, done=0, Sum=0, Cout=0, no done pulse. A subsequent start computes correctly.
